// File: rtl/muxkey_lookup_sched_pkg.sv
// Shared constants, types and helpers for the time-shared MuxKey lookup scheduler.
package muxkey_lookup_sched_pkg;

    localparam int unsigned NR_REQ_DEF   = 4;
    localparam int unsigned NR_KEY_DEF   = 8;
    localparam int unsigned KEY_LEN_DEF  = 4;
    localparam int unsigned DATA_LEN_DEF = 8;
    localparam int unsigned STAT_W       = 16;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    // Index width that never collapses to zero bits for single-entry configurations.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/muxkey_lookup_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the rotating pointer is owned by the parent.
module rr_arbiter
    import muxkey_lookup_sched_pkg::*;
#(
    parameter int unsigned N   = NR_REQ_DEF,
    parameter int unsigned IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    // Scan from ptr upward modulo N; the first active request wins.
    always_comb begin
        logic           found;
        logic [IDW-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < int'(N); k++) begin
            idx = IDW'((int'(ptr) + k) % int'(N));
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = en;
                gnt_id   = idx;
            end
        end
    end

endmodule

// File: rtl/muxkey_lookup_sched.sv
// Shares one programmable {key,data} lookup table between NR_REQ requesters
// through a round-robin arbiter and a single registered response slot.
module muxkey_lookup_sched
    import muxkey_lookup_sched_pkg::*;
#(
    parameter int unsigned NR_REQ   = NR_REQ_DEF,
    parameter int unsigned NR_KEY   = NR_KEY_DEF,
    parameter int unsigned KEY_LEN  = KEY_LEN_DEF,
    parameter int unsigned DATA_LEN = DATA_LEN_DEF,
    parameter int unsigned ID_W     = clog2_min1(NR_REQ),
    parameter int unsigned IDX_W    = clog2_min1(NR_KEY)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NR_REQ-1:0]           req_valid,
    input  logic [NR_REQ*KEY_LEN-1:0]   req_key,
    output logic [NR_REQ-1:0]           req_ready,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [ID_W-1:0]             resp_id,
    output logic                        resp_hit,
    output logic [DATA_LEN-1:0]         resp_data,
    input  logic                        cfg_we,
    input  logic [IDX_W-1:0]            cfg_idx,
    input  logic [KEY_LEN-1:0]          cfg_key,
    input  logic [DATA_LEN-1:0]         cfg_data,
    input  logic                        cfg_clr,
    output logic [STAT_W-1:0]           stat_lookups,
    output logic [STAT_W-1:0]           stat_misses
);

    slot_state_t         state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     resp_id_d;
    logic                resp_hit_d;
    logic [DATA_LEN-1:0] resp_data_d;
    logic [STAT_W-1:0]   stat_lookups_d, stat_misses_d;

    logic [NR_KEY-1:0]   ent_valid;
    logic [KEY_LEN-1:0]  ent_key  [NR_KEY];
    logic [DATA_LEN-1:0] ent_data [NR_KEY];

    logic                can_issue;
    logic                accept;
    logic [ID_W-1:0]     gnt_id;
    logic [KEY_LEN-1:0]  key_arr [NR_REQ];
    logic [KEY_LEN-1:0]  gnt_key;
    logic                match_hit;
    logic [DATA_LEN-1:0] match_data;

    assign resp_valid = (state_q == SLOT_FULL);
    assign can_issue  = !resp_valid || resp_ready;
    assign accept     = |req_ready;

    // Grants are suppressed during reset so nothing is accepted that cycle.
    rr_arbiter #(
        .N   (NR_REQ),
        .IDW (ID_W)
    ) u_arb (
        .req    (req_valid),
        .ptr    (ptr_q),
        .en     (can_issue && !rst),
        .gnt    (req_ready),
        .gnt_id (gnt_id)
    );

    always_comb begin
        for (int i = 0; i < int'(NR_REQ); i++) begin
            key_arr[i] = req_key[i*KEY_LEN +: KEY_LEN];
        end
    end

    assign gnt_key = key_arr[gnt_id];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match_hit  = 1'b0;
        match_data = '0;
        for (int j = int'(NR_KEY) - 1; j >= 0; j--) begin
            if (ent_valid[j] && (ent_key[j] == gnt_key)) begin
                match_hit  = 1'b1;
                match_data = ent_data[j];
            end
        end
    end

    // Slot next-state, response capture, pointer advance and statistics.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        resp_id_d      = resp_id;
        resp_hit_d     = resp_hit;
        resp_data_d    = resp_data;
        stat_lookups_d = stat_lookups;
        stat_misses_d  = stat_misses;

        case (state_q)
            SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
            SLOT_FULL: begin
                if (accept)          state_d = SLOT_FULL;
                else if (resp_ready) state_d = SLOT_EMPTY;
            end
            default: state_d = SLOT_EMPTY;
        endcase

        if (accept) begin
            ptr_d       = ID_W'((int'(gnt_id) + 1) % int'(NR_REQ));
            resp_id_d   = gnt_id;
            resp_hit_d  = match_hit;
            resp_data_d = match_data;
            if (stat_lookups != '1) stat_lookups_d = stat_lookups + STAT_W'(1);
            if (!match_hit && (stat_misses != '1)) stat_misses_d = stat_misses + STAT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= SLOT_EMPTY;
            ptr_q        <= '0;
            resp_id      <= '0;
            resp_hit     <= 1'b0;
            resp_data    <= '0;
            stat_lookups <= '0;
            stat_misses  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            resp_id      <= resp_id_d;
            resp_hit     <= resp_hit_d;
            resp_data    <= resp_data_d;
            stat_lookups <= stat_lookups_d;
            stat_misses  <= stat_misses_d;
        end
    end

    // Table update: a clear lands first, so a same-cycle write survives it.
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid <= '0;
            for (int j = 0; j < int'(NR_KEY); j++) begin
                ent_key[j]  <= '0;
                ent_data[j] <= '0;
            end
        end else begin
            if (cfg_clr) ent_valid <= '0;
            if (cfg_we && (32'(cfg_idx) < NR_KEY)) begin
                ent_valid[cfg_idx] <= 1'b1;
                ent_key[cfg_idx]   <= cfg_key;
                ent_data[cfg_idx]  <= cfg_data;
            end
        end
    end

endmodule

// File: tb/tb_muxkey_lookup_sched.sv
// Directed bench for muxkey_lookup_sched with hand-computed expectations.
module tb_muxkey_lookup_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [15:0] req_key = '0;
    logic [3:0]  req_ready;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [1:0]  resp_id;
    logic        resp_hit;
    logic [7:0]  resp_data;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_idx = '0;
    logic [3:0]  cfg_key = '0;
    logic [7:0]  cfg_data = '0;
    logic        cfg_clr = 1'b0;
    logic [15:0] stat_lookups;
    logic [15:0] stat_misses;

    int ntests = 0;
    int nfail  = 0;

    muxkey_lookup_sched dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_key      (req_key),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_id      (resp_id),
        .resp_hit     (resp_hit),
        .resp_data    (resp_data),
        .cfg_we       (cfg_we),
        .cfg_idx      (cfg_idx),
        .cfg_key      (cfg_key),
        .cfg_data     (cfg_data),
        .cfg_clr      (cfg_clr),
        .stat_lookups (stat_lookups),
        .stat_misses  (stat_misses)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] idx, input logic [3:0] k, input logic [7:0] d);
        cfg_we = 1'b1; cfg_idx = idx; cfg_key = k; cfg_data = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 4'b1111;
        #1;
        ntests++; if (req_ready !== 4'b0000) begin nfail++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
        step();
        rst = 1'b0; req_valid = '0;
        #1;
        ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
        ntests++; if ({resp_id, resp_hit, resp_data} !== 11'd0) begin nfail++; $display("FAIL reset_resp got %h/%b/%h exp 0/0/00", resp_id, resp_hit, resp_data); end
        ntests++; if ({stat_lookups, stat_misses} !== 32'd0) begin nfail++; $display("FAIL reset_stats got %0d/%0d exp 0/0", stat_lookups, stat_misses); end
    endtask

    task automatic test_hit();
        cfg_write(3'd0, 4'h3, 8'hA5);
        cfg_write(3'd1, 4'h7, 8'h5C);
        req_valid = 4'b0001; req_key = 16'h0003;
        #1;
        ntests++; if (req_ready !== 4'b0001) begin nfail++; $display("FAIL hit_ready got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_id, resp_hit, resp_data} !== {1'b1, 2'd0, 1'b1, 8'hA5}) begin
            nfail++; $display("FAIL hit_resp got v%b id%0d h%b d%h exp v1 id0 h1 dA5", resp_valid, resp_id, resp_hit, resp_data); end
        ntests++; if (stat_lookups !== 16'd1) begin nfail++; $display("FAIL hit_lookups got %0d exp 1", stat_lookups); end
        step();
        ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL hit_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_miss();
        req_valid = 4'b0100; req_key = 16'h0F00;
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_id, resp_hit, resp_data} !== {1'b1, 2'd2, 1'b0, 8'h00}) begin
            nfail++; $display("FAIL miss_resp got v%b id%0d h%b d%h exp v1 id2 h0 d00", resp_valid, resp_id, resp_hit, resp_data); end
        ntests++; if (stat_misses !== 16'd1) begin nfail++; $display("FAIL miss_count got %0d exp 1", stat_misses); end
        step();
        cfg_clr = 1'b1;
        step();
        cfg_clr = 1'b0;
        req_valid = 4'b0001; req_key = 16'h0003;
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_id, resp_hit, resp_data} !== {1'b1, 2'd0, 1'b0, 8'h00}) begin
            nfail++; $display("FAIL clr_resp got v%b id%0d h%b d%h exp v1 id0 h0 d00", resp_valid, resp_id, resp_hit, resp_data); end
        ntests++; if ({stat_lookups, stat_misses} !== {16'd3, 16'd2}) begin nfail++; $display("FAIL clr_stats got %0d/%0d exp 3/2", stat_lookups, stat_misses); end
        step();
    endtask

    task automatic test_fairness();
        logic [1:0] exp_id [5];
        exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd3; exp_id[4] = 2'd0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 4'b1111; req_key = 16'h3210;
        #1;
        ntests++; if (req_ready !== 4'b0001) begin nfail++; $display("FAIL fair_first got %b exp 0001", req_ready); end
        for (int i = 0; i < 5; i++) begin
            step();
            ntests++; if ({resp_valid, resp_id} !== {1'b1, exp_id[i]}) begin
                nfail++; $display("FAIL fair_grant%0d got v%b id%0d exp v1 id%0d", i, resp_valid, resp_id, exp_id[i]); end
        end
        ntests++; if ({stat_lookups, stat_misses} !== {16'd5, 16'd5}) begin nfail++; $display("FAIL fair_stats got %0d/%0d exp 5/5", stat_lookups, stat_misses); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            ntests++; if (req_ready !== 4'b0000) begin nfail++; $display("FAIL bp_ready%0d got %b exp 0000", i, req_ready); end
            step();
            ntests++; if ({resp_valid, resp_id, resp_hit, resp_data, stat_lookups} !== {1'b1, 2'd0, 1'b0, 8'h00, 16'd5}) begin
                nfail++; $display("FAIL bp_hold%0d got v%b id%0d h%b d%h n%0d exp v1 id0 h0 d00 n5", i, resp_valid, resp_id, resp_hit, resp_data, stat_lookups); end
        end
        resp_ready = 1'b1;
        #1;
        ntests++; if (req_ready !== 4'b0010) begin nfail++; $display("FAIL bp_release got %b exp 0010", req_ready); end
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_id, stat_lookups} !== {1'b1, 2'd1, 16'd6}) begin
            nfail++; $display("FAIL bp_next got v%b id%0d n%0d exp v1 id1 n6", resp_valid, resp_id, stat_lookups); end
        step();
        ntests++; if (resp_valid !== 1'b0) begin nfail++; $display("FAIL bp_drain got %b exp 0", resp_valid); end
    endtask

    task automatic test_same_cycle_cfg();
        cfg_write(3'd1, 4'h7, 8'h5C);
        req_valid = 4'b0001; req_key = 16'h0007;
        cfg_we = 1'b1; cfg_idx = 3'd1; cfg_key = 4'h7; cfg_data = 8'h11;
        step();
        cfg_we = 1'b0;
        ntests++; if ({resp_hit, resp_data} !== {1'b1, 8'h5C}) begin nfail++; $display("FAIL same_old got h%b d%h exp h1 d5C", resp_hit, resp_data); end
        step();
        req_valid = '0;
        ntests++; if ({resp_hit, resp_data} !== {1'b1, 8'h11}) begin nfail++; $display("FAIL same_new got h%b d%h exp h1 d11", resp_hit, resp_data); end
        cfg_write(3'd2, 4'h9, 8'h33);
        cfg_write(3'd5, 4'h9, 8'h66);
        req_valid = 4'b0001; req_key = 16'h0009;
        step();
        req_valid = '0;
        ntests++; if ({resp_hit, resp_data} !== {1'b1, 8'h33}) begin nfail++; $display("FAIL dup_low got h%b d%h exp h1 d33", resp_hit, resp_data); end
        cfg_clr = 1'b1;
        cfg_write(3'd3, 4'h9, 8'h77);
        cfg_clr = 1'b0;
        req_valid = 4'b0001; req_key = 16'h0009;
        step();
        ntests++; if ({resp_hit, resp_data} !== {1'b1, 8'h77}) begin nfail++; $display("FAIL clr_we got h%b d%h exp h1 d77", resp_hit, resp_data); end
        req_key = 16'h0007;
        step();
        req_valid = '0;
        ntests++; if ({resp_hit, resp_data} !== {1'b0, 8'h00}) begin nfail++; $display("FAIL clr_we_miss got h%b d%h exp h0 d00", resp_hit, resp_data); end
        ntests++; if ({stat_lookups, stat_misses} !== {16'd11, 16'd7}) begin nfail++; $display("FAIL same_stats got %0d/%0d exp 11/7", stat_lookups, stat_misses); end
        step();
    endtask

    task automatic test_reset_stall();
        resp_ready = 1'b0;
        req_valid = 4'b0001; req_key = 16'h0009;
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_hit, resp_data} !== {1'b1, 1'b1, 8'h77}) begin
            nfail++; $display("FAIL stall_fill got v%b h%b d%h exp v1 h1 d77", resp_valid, resp_hit, resp_data); end
        step();
        rst = 1'b1; req_valid = 4'b1111; req_key = 16'h9999;
        step();
        rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
        #1;
        ntests++; if ({resp_valid, resp_id, resp_hit, resp_data} !== 12'd0) begin
            nfail++; $display("FAIL rst_stall_resp got v%b id%0d h%b d%h exp all 0", resp_valid, resp_id, resp_hit, resp_data); end
        ntests++; if ({stat_lookups, stat_misses} !== 32'd0) begin nfail++; $display("FAIL rst_stall_stats got %0d/%0d exp 0/0", stat_lookups, stat_misses); end
        req_valid = 4'b1111;
        #1;
        ntests++; if (req_ready !== 4'b0001) begin nfail++; $display("FAIL rst_stall_ptr got %b exp 0001", req_ready); end
        step();
        req_valid = '0;
        ntests++; if ({resp_valid, resp_id, resp_hit, resp_data} !== {1'b1, 2'd0, 1'b0, 8'h00}) begin
            nfail++; $display("FAIL rst_stall_lookup got v%b id%0d h%b d%h exp v1 id0 h0 d00", resp_valid, resp_id, resp_hit, resp_data); end
        ntests++; if ({stat_lookups, stat_misses} !== {16'd1, 16'd1}) begin nfail++; $display("FAIL rst_stall_cnt got %0d/%0d exp 1/1", stat_lookups, stat_misses); end
    endtask

    initial begin
        #2;
        test_reset();
        test_hit();
        test_miss();
        test_fairness();
        test_backpressure();
        test_same_cycle_cfg();
        test_reset_stall();
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
